// File: rtl/serdesphy_ana_pll_cal_ctrl.sv
// PLL VCO coarse-tune calibration: 8-step MSB-first SAR on vco_control,
// with each step measured by gating a vco_clk edge counter over a clk window.
`timescale 1ns/1ps
module serdesphy_ana_pll_cal_ctrl #(
  parameter int WIN_CYCLES    = 64,
  parameter int SETTLE_CYC    = 16,
  parameter int READY_TIMEOUT = 4096,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vco_clk,
  input  logic             vco_ready,
  input  logic             start,
  input  logic [CNT_W-1:0] target_count,
  input  logic [7:0]       tol,
  output logic             vco_enable,
  output logic [7:0]       vco_control,
  output logic             busy,
  output logic             done,
  output logic             cal_ok,
  output logic             error,
  output logic [CNT_W-1:0] meas_count
);

  // state   | meaning
  // IDLE    | waiting for start after reset
  // PWRUP   | VCO enabled, waiting for synchronized vco_ready (bounded)
  // SETTLE  | VCO settling after a code change
  // GATE    | measurement window open, vco_clk counter running
  // DRAIN   | window closed, letting the VCO-domain gate flush
  // COMPARE | SAR bit decision, or verify tolerance check
  // DONE    | calibration finished, final code held
  // ERR     | vco_ready timeout, VCO disabled
  typedef enum logic [2:0] {
    S_IDLE, S_PWRUP, S_SETTLE, S_GATE, S_DRAIN, S_COMPARE, S_DONE, S_ERR
  } state_t;

  localparam int MAX_A   = (READY_TIMEOUT > WIN_CYCLES) ? READY_TIMEOUT : WIN_CYCLES;
  localparam int TMR_MAX = (MAX_A > SETTLE_CYC) ? MAX_A : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 4);

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [2:0]         bit_q, bit_d;
  logic               verify_q, verify_d;
  logic [7:0]         ctrl_q, ctrl_d;
  logic               en_q, en_d;
  logic               done_q, done_d;
  logic               ok_q, ok_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   meas_q, meas_d;
  logic               gate_q, gate_d;
  logic               rdy_s1_q, rdy_s2_q;

  logic               gs1_q, gs2_q, gs3_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [CNT_W:0]     diff;

  assign diff = (meas_q >= target_count) ?
                ({1'b0, meas_q} - {1'b0, target_count}) :
                ({1'b0, target_count} - {1'b0, meas_q});

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    bit_d    = bit_q;
    verify_d = verify_q;
    ctrl_d   = ctrl_q;
    en_d     = en_q;
    done_d   = done_q;
    ok_d     = ok_q;
    err_d    = err_q;
    meas_d   = meas_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          done_d   = 1'b0;
          ok_d     = 1'b0;
          err_d    = 1'b0;
          ctrl_d   = 8'h80;
          en_d     = 1'b1;
          bit_d    = 3'd7;
          verify_d = 1'b0;
          tmr_d    = TMR_W'(READY_TIMEOUT - 1);
          state_d  = S_PWRUP;
        end
      end
      S_PWRUP: begin
        if (rdy_s2_q) begin
          tmr_d   = TMR_W'(SETTLE_CYC - 1);
          state_d = S_SETTLE;
        end else if (tmr_q == '0) begin
          en_d    = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_ERR;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_SETTLE: begin
        if (tmr_q == '0) begin
          tmr_d   = TMR_W'(WIN_CYCLES - 1);
          state_d = S_GATE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_GATE: begin
        if (tmr_q == '0) begin
          tmr_d   = TMR_W'(3);
          state_d = S_DRAIN;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_DRAIN: begin
        // Counter has been idle since early DRAIN, so a direct capture is safe.
        if (tmr_q == '0) begin
          meas_d  = cnt_q;
          state_d = S_COMPARE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_COMPARE: begin
        if (verify_q) begin
          ok_d    = (diff <= (CNT_W+1)'(tol));
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          if (meas_q > target_count) ctrl_d[bit_q] = 1'b0;
          if (bit_q != 3'd0) begin
            ctrl_d[bit_q - 3'd1] = 1'b1;
            bit_d = bit_q - 3'd1;
          end else begin
            verify_d = 1'b1;
          end
          tmr_d   = TMR_W'(SETTLE_CYC - 1);
          state_d = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    gate_d = (state_d == S_GATE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      bit_q    <= '0;
      verify_q <= 1'b0;
      ctrl_q   <= 8'h80;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      meas_q   <= '0;
      gate_q   <= 1'b0;
      rdy_s1_q <= 1'b0;
      rdy_s2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      bit_q    <= bit_d;
      verify_q <= verify_d;
      ctrl_q   <= ctrl_d;
      en_q     <= en_d;
      done_q   <= done_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      meas_q   <= meas_d;
      gate_q   <= gate_d;
      rdy_s1_q <= vco_ready;
      rdy_s2_q <= rdy_s1_q;
    end
  end

  // gs3 lags gs2 by one vco_clk edge so the window opening loads rather than adds.
  always_comb begin
    cnt_d = cnt_q;
    if (gs2_q && !gs3_q) cnt_d = CNT_W'(1);
    else if (gs2_q && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge vco_clk or negedge rst_n) begin
    if (!rst_n) begin
      gs1_q <= 1'b0;
      gs2_q <= 1'b0;
      gs3_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      gs1_q <= gate_q;
      gs2_q <= gs1_q;
      gs3_q <= gs2_q;
      cnt_q <= cnt_d;
    end
  end

  assign busy        = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign vco_enable  = en_q;
  assign vco_control = ctrl_q;
  assign done        = done_q;
  assign cal_ok      = ok_q;
  assign error       = err_q;
  assign meas_count  = meas_q;

endmodule

// File: tb/tb_serdesphy_ana_pll_cal_ctrl.sv
// Directed bench for the PLL VCO calibration sequencer; the VCO is modelled as
// a burst generator whose per-window edge count is a known function of the code.
`timescale 1ns/1ps
module tb_serdesphy_ana_pll_cal_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vco_clk;
  logic        vco_ready = 1'b0;
  logic        start = 1'b0;
  logic [15:0] target_count = '0;
  logic [7:0]  tol = '0;
  logic        vco_enable;
  logic [7:0]  vco_control;
  logic        busy, done, cal_ok, error;
  logic [15:0] meas_count;

  int n_chk = 0;
  int n_err = 0;
  bit sat_mode = 1'b0;

  serdesphy_ana_pll_cal_ctrl dut (
    .clk(clk), .rst_n(rst_n), .vco_clk(vco_clk), .vco_ready(vco_ready),
    .start(start), .target_count(target_count), .tol(tol),
    .vco_enable(vco_enable), .vco_control(vco_control), .busy(busy),
    .done(done), .cal_ok(cal_ok), .error(error), .meas_count(meas_count)
  );

  always #500 clk = ~clk;

  // Bursts follow a 64-cycle pattern summing to count(code), so any 64-cycle
  // gate window sees exactly count(code) edges: 1024+4*code, or >0xFFFF when saturating.
  initial begin
    int ph, c, n;
    ph = 0;
    vco_clk = 1'b0;
    forever begin
      @(posedge clk);
      #100;
      c = sat_mode ? 66560 : (1024 + 4 * int'(vco_control));
      n = c / 64 + ((ph < (c % 64)) ? 1 : 0);
      ph = (ph + 1) % 64;
      repeat (n) begin
        vco_clk = 1'b1; #0.3;
        vco_clk = 1'b0; #0.3;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start sampled at edge 0; with vco_ready already synchronized, PWRUP lasts
  // one cycle and the 9 x 85-cycle measurements begin at cycle 2, so done at 767.
  task automatic run_cal(input string tag, input logic [15:0] tgt, input logic [7:0] tl,
                         input int pa, input int pb, input int exp_lat,
                         input logic [7:0] exp_code, input logic [15:0] exp_meas,
                         input logic exp_ok, input logic exp_err);
    int lat;
    target_count = tgt;
    tol = tl;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check_val({tag, " done_clr"}, {31'd0, done}, 32'd0);
    check_val({tag, " busy_set"}, {31'd0, busy}, 32'd1);
    lat = 1;
    while (!done && lat < 6000) begin
      start = (lat == pa) || (lat == pb);
      tick(1);
      lat++;
    end
    start = 1'b0;
    check_val({tag, " latency"}, lat, exp_lat);
    check_val({tag, " busy_end"}, {31'd0, busy}, 32'd0);
    check_val({tag, " code"}, {24'd0, vco_control}, {24'd0, exp_code});
    check_val({tag, " cal_ok"}, {31'd0, cal_ok}, {31'd0, exp_ok});
    check_val({tag, " error"}, {31'd0, error}, {31'd0, exp_err});
    check_val({tag, " vco_en"}, {31'd0, vco_enable}, {31'd0, !exp_err});
    if (!exp_err) check_val({tag, " meas"}, {16'd0, meas_count}, {16'd0, exp_meas});
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, " vco_en"}, {31'd0, vco_enable}, 32'd0);
    check_val({tag, " code"}, {24'd0, vco_control}, 32'h80);
    check_val({tag, " busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, " done"}, {31'd0, done}, 32'd0);
    check_val({tag, " cal_ok"}, {31'd0, cal_ok}, 32'd0);
    check_val({tag, " error"}, {31'd0, error}, 32'd0);
    check_val({tag, " meas"}, {16'd0, meas_count}, 32'd0);
  endtask

  initial begin
    tick(3);
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick(3);

    // vco_ready held low: ERR at cycle 1 + 4096
    run_cal("tmo", 16'd1536, 8'd8, -1, -1, 4097, 8'h80, 16'h0, 1'b0, 1'b1);

    vco_ready = 1'b1;
    tick(4);
    run_cal("nom", 16'd1536, 8'd8, -1, -1, 767, 8'h80, 16'd1536, 1'b1, 1'b0);
    // restart from DONE, with start pulses during SETTLE (cycle 5) and GATE (cycle 30)
    run_cal("bsy", 16'd1536, 8'd8, 5, 30, 767, 8'h80, 16'd1536, 1'b1, 1'b0);
    run_cal("t0", 16'd0, 8'd8, -1, -1, 767, 8'h00, 16'd1024, 1'b0, 1'b0);
    run_cal("tmax", 16'hFFFF, 8'd8, -1, -1, 767, 8'hFF, 16'd2044, 1'b0, 1'b0);
    // |1536 - 1539| = 3: inside tol 3, outside tol 2
    run_cal("tolin", 16'd1539, 8'd3, -1, -1, 767, 8'h80, 16'd1536, 1'b1, 1'b0);
    run_cal("tolout", 16'd1539, 8'd2, -1, -1, 767, 8'h80, 16'd1536, 1'b0, 1'b0);

    sat_mode = 1'b1;
    run_cal("sat", 16'd100, 8'd8, -1, -1, 767, 8'h00, 16'hFFFF, 1'b0, 1'b0);
    sat_mode = 1'b0;

    // third GATE spans cycles 188..251 after start
    target_count = 16'd1536;
    tol = 8'd8;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(199);
    check_val("midgate busy", {31'd0, busy}, 32'd1);
    #200;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    tick(3);
    rst_n = 1'b1;
    tick(5);
    run_cal("post", 16'd1536, 8'd8, -1, -1, 767, 8'h80, 16'd1536, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
